// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the fetch stage: opcodes, instruction field positions,
// PC width and the fetch FSM state type.
package mips_pkg;

    localparam int PC_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int JADDR_MSB  = 25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EXEC = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: jump, taken branch, or sequential.
// Kept separate so a future pipelined fetch can reuse it.
module next_pc_logic
    import mips_pkg::*;
(
    input  logic [PC_W-1:0] pc_plus4,
    input  logic [15:0]     imm,
    input  logic [25:0]     jaddr,
    input  logic            Branch,
    input  logic            Jump,
    input  logic            Zero,
    output logic [PC_W-1:0] next_pc
);

    logic [PC_W-1:0] branch_offset;

    assign branch_offset = {{14{imm[15]}}, imm, 2'b00};

    // NOTE: next_pc gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        next_pc = pc_plus4;
        if (Jump) begin
            next_pc = {pc_plus4[31:28], jaddr, 2'b00};
        end else if (Branch && Zero) begin
            next_pc = pc_plus4 + branch_offset;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch: holds the PC, fetches over req/ack, decodes MIPS
// fields for ControlUnit/datapath and advances the PC when downstream retires.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0040_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            exec_done,
    input  logic            Branch,
    input  logic            Jump,
    input  logic            Zero,
    output logic            instr_valid,
    output logic [5:0]      opcode,
    output logic [5:0]      Funct,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [15:0]     imm,
    output logic [25:0]     jaddr,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic [31:0]     instr_count
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [31:0]     instr_reg;
    logic [PC_W-1:0] next_pc;
    logic            load_instr;
    logic            retire;

    always_comb begin
        state_next = state;
        load_instr = 1'b0;
        retire     = 1'b0;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (imem_ack) begin
                    load_instr = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (exec_done && !stall) begin
                    retire     = 1'b1;
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Acks outside REQ never reach load_instr, so stale or spurious acks are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            instr_reg   <= '0;
            instr_count <= '0;
        end else begin
            if (load_instr) begin
                instr_reg <= imem_rdata;
            end
            if (retire) begin
                pc          <= next_pc;
                instr_count <= instr_count + 32'd1;
            end
        end
    end

    assign imem_req    = (state == REQ);
    assign imem_addr   = pc;
    assign instr_valid = (state == EXEC);
    assign pc_plus4    = pc + 32'd4;

    assign opcode = instr_reg[OPCODE_MSB:OPCODE_LSB];
    assign rs     = instr_reg[RS_MSB:RS_LSB];
    assign rt     = instr_reg[RT_MSB:RT_LSB];
    assign rd     = instr_reg[RD_MSB:RD_LSB];
    assign shamt  = instr_reg[SHAMT_MSB:SHAMT_LSB];
    assign Funct  = instr_reg[FUNCT_MSB:FUNCT_LSB];
    assign imm    = instr_reg[IMM_MSB:0];
    assign jaddr  = instr_reg[JADDR_MSB:0];

    next_pc_logic u_next_pc (
        .pc_plus4 (pc_plus4),
        .imm      (imm),
        .jaddr    (jaddr),
        .Branch   (Branch),
        .Jump     (Jump),
        .Zero     (Zero),
        .next_pc  (next_pc)
    );

endmodule
